// File: rtl/issue_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// issue_scheduler_pkg
// Shared definitions for the issue scheduler:
//   owner_e        : 2-bit CDB owner codes (none / int / mul / div)
//   DEF_*          : default execution latencies and starvation threshold
//   CNT_W          : width of the divider countdown and integer wait counters
// ----------------------------------------------------------------------------
package issue_scheduler_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INT  = 2'd1,
    OWN_MUL  = 2'd2,
    OWN_DIV  = 2'd3
  } owner_e;

  localparam int DEF_INT_LAT      = 1;
  localparam int DEF_MUL_LAT      = 4;
  localparam int DEF_DIV_LAT      = 8;
  localparam int DEF_STARVE_LIMIT = 3;

  // Both the divider countdown (max DIV_LAT-1 <= 14) and the saturating
  // integer wait counter fit in 4 bits.
  localparam int CNT_W = 4;

endpackage

// File: rtl/issue_scheduler_if.sv
// ----------------------------------------------------------------------------
// issue_scheduler_if
// Handshake bundle between the issue queues / ROB (master side) and the
// issue scheduler (slave side).
//   int_ready, mul_ready, div_ready : queue holds an issuable entry
//   flush_valid                     : ROB flush, clears all scheduling state
//   issue_int, issue_mul, issue_div : same-cycle issue grants
//   cdb_owner_valid, cdb_owner      : unit writing the CDB this cycle
//   div_busy                        : divider occupied
//   int_starved                     : integer starvation priority active
// ----------------------------------------------------------------------------
interface issue_scheduler_if;
  import issue_scheduler_pkg::*;

  logic       int_ready;
  logic       mul_ready;
  logic       div_ready;
  logic       flush_valid;
  logic       issue_int;
  logic       issue_mul;
  logic       issue_div;
  logic       cdb_owner_valid;
  logic [1:0] cdb_owner;
  logic       div_busy;
  logic       int_starved;

  modport master (
    output int_ready, mul_ready, div_ready, flush_valid,
    input  issue_int, issue_mul, issue_div,
    input  cdb_owner_valid, cdb_owner, div_busy, int_starved
  );

  modport slave (
    input  int_ready, mul_ready, div_ready, flush_valid,
    output issue_int, issue_mul, issue_div,
    output cdb_owner_valid, cdb_owner, div_busy, int_starved
  );

endinterface

// File: rtl/issue_scheduler_cdb_reservation_shifter.sv
// ----------------------------------------------------------------------------
// cdb_reservation_shifter
// Future-occupancy map of the common data bus. Entry i holds the owner of the
// CDB i cycles from now; entry 0 is the current owner. The map shifts down by
// one every cycle and accepts one reservation per cycle.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   flush_i       : synchronous clear of every reservation
//   wr_owner_i    : owner to reserve (OWN_NONE = no write); the target entry
//                   is implied by that owner's latency
//   owner_o       : current CDB owner (entry 0, registered)
//   int_free_o    : CDB slot INT_LAT cycles ahead is free
//   mul_free_o    : CDB slot MUL_LAT cycles ahead is free
//   div_free_o    : CDB slot DIV_LAT cycles ahead is free
// ----------------------------------------------------------------------------
module cdb_reservation_shifter
  import issue_scheduler_pkg::*;
#(
  parameter int INT_LAT = DEF_INT_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic [1:0] wr_owner_i,
  output logic [1:0] owner_o,
  output logic       int_free_o,
  output logic       mul_free_o,
  output logic       div_free_o
);

  logic [DIV_LAT:0][1:0] rsv_q;
  logic [DIV_LAT:0][1:0] rsv_d;

  genvar gi;
  generate
    for (gi = 0; gi <= DIV_LAT; gi++) begin : g_slot
      logic [1:0] shifted;
      logic       wr_hit;

      if (gi == DIV_LAT) begin : g_top
        assign shifted = OWN_NONE;
      end else begin : g_mid
        assign shifted = rsv_q[gi+1];
      end

      // A unit with latency L is looked up at entry L this cycle; after the
      // shift that same slot sits at L-1, so the reservation lands there.
      // The lookup already proved it free, so this never clobbers a live entry.
      assign wr_hit = ((wr_owner_i == OWN_INT) && (gi == INT_LAT - 1)) ||
                      ((wr_owner_i == OWN_MUL) && (gi == MUL_LAT - 1)) ||
                      ((wr_owner_i == OWN_DIV) && (gi == DIV_LAT - 1));

      assign rsv_d[gi] = flush_i ? OWN_NONE : (wr_hit ? wr_owner_i : shifted);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsv_q <= '0;
    end else begin
      rsv_q <= rsv_d;
    end
  end

  assign owner_o    = rsv_q[0];
  assign int_free_o = (rsv_q[INT_LAT] == OWN_NONE);
  assign mul_free_o = (rsv_q[MUL_LAT] == OWN_NONE);
  assign div_free_o = (rsv_q[DIV_LAT] == OWN_NONE);

endmodule

// File: rtl/issue_scheduler.sv
// ----------------------------------------------------------------------------
// issue_scheduler
// Issue-stage arbiter. Each cycle grants at most one of the integer, multiply
// and divide queues, reserving the CDB slot at that unit's fixed latency so
// results never collide, and reports the current CDB owner.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : issue_scheduler_if.slave (readies and flush in; grants,
//            CDB owner, div_busy and int_starved out)
// ----------------------------------------------------------------------------
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int INT_LAT      = DEF_INT_LAT,
  parameter int MUL_LAT      = DEF_MUL_LAT,
  parameter int DIV_LAT      = DEF_DIV_LAT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  issue_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] STARVE_TH  = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] WAIT_MAX   = '1;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] int_wait_q, int_wait_d;

  logic [1:0] cur_owner;
  logic       int_free, mul_free, div_free;
  logic       div_busy, int_starved;
  logic       elig_int, elig_mul, elig_div;
  logic       grant_int, grant_mul, grant_div;
  logic [1:0] wr_owner;

  cdb_reservation_shifter #(
    .INT_LAT (INT_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_rsv (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (bus.flush_valid),
    .wr_owner_i (wr_owner),
    .owner_o    (cur_owner),
    .int_free_o (int_free),
    .mul_free_o (mul_free),
    .div_free_o (div_free)
  );

  assign div_busy    = (div_cnt_q != '0);
  assign int_starved = (int_wait_q >= STARVE_TH);

  assign elig_int = bus.int_ready & int_free;
  assign elig_mul = bus.mul_ready & mul_free & ~int_starved;
  assign elig_div = bus.div_ready & div_free & ~div_busy & ~int_starved;

  // Starvation makes integer the sole candidate; otherwise the longest
  // latency unit wins, since its slot is the hardest to find free again.
  // Reset is included so grants stay low for the whole reset window.
  always_comb begin
    grant_int = 1'b0;
    grant_mul = 1'b0;
    grant_div = 1'b0;
    if (!rst_i && !bus.flush_valid) begin
      if (int_starved) begin
        grant_int = elig_int;
      end else if (elig_div) begin
        grant_div = 1'b1;
      end else if (elig_mul) begin
        grant_mul = 1'b1;
      end else if (elig_int) begin
        grant_int = 1'b1;
      end
    end
  end

  always_comb begin
    wr_owner = OWN_NONE;
    if (grant_div) begin
      wr_owner = OWN_DIV;
    end else if (grant_mul) begin
      wr_owner = OWN_MUL;
    end else if (grant_int) begin
      wr_owner = OWN_INT;
    end
  end

  // Divider countdown: reload on issue, decrement to zero and hold.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (bus.flush_valid) begin
      div_cnt_d = '0;
    end else if (grant_div) begin
      div_cnt_d = DIV_RELOAD;
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - 1'b1;
    end
  end

  // Consecutive cycles the integer queue was ready but not granted.
  always_comb begin
    int_wait_d = int_wait_q;
    if (bus.flush_valid || !bus.int_ready || grant_int) begin
      int_wait_d = '0;
    end else if (int_wait_q != WAIT_MAX) begin
      int_wait_d = int_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q  <= '0;
      int_wait_q <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      int_wait_q <= int_wait_d;
    end
  end

  assign bus.issue_int       = grant_int;
  assign bus.issue_mul       = grant_mul;
  assign bus.issue_div       = grant_div;
  assign bus.cdb_owner       = cur_owner;
  assign bus.cdb_owner_valid = (cur_owner != OWN_NONE) & ~bus.flush_valid;
  assign bus.div_busy        = div_busy;
  assign bus.int_starved     = int_starved;

endmodule

// File: tb/tb_issue_scheduler.sv
// ----------------------------------------------------------------------------
// tb_issue_scheduler
// Self-checking bench for issue_scheduler (INT_LAT=1, MUL_LAT=4, DIV_LAT=8,
// STARVE_LIMIT=3). A cycle-indexed reference model predicts grants and status;
// every predicted grant pushes its CDB cycle and owner onto a scoreboard that
// is consumed when that cycle arrives. Directed scenarios add fixed expected
// grant / CDB owner values.
// ----------------------------------------------------------------------------
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_scheduler_if bus_if ();

  issue_scheduler #(
    .INT_LAT      (1),
    .MUL_LAT      (4),
    .DIV_LAT      (8),
    .STARVE_LIMIT (3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  typedef struct {
    int         cyc;
    logic [1:0] own;
  } sb_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_cyc    = 0;
  int         m_div_free = 0;
  int         m_wait   = 0;
  logic [1:0] m_slot [64];
  sb_t        sb_q [$];
  bit         verbose  = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, m_cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 64; k++) m_slot[k] = OWN_NONE;
    m_div_free = 0;
    m_wait     = 0;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs, compare DUT with the model, advance model.
  // eg / eo: directed expected grant code / CDB owner, -1 = don't care.
  task automatic step(input logic ri, input logic rm, input logic rd,
                      input logic fl, input logic rs, input int eg, input int eo);
    logic       starved, busy, fi, fm, fd, gi, gm, gd, matched;
    logic [1:0] cur;
    int         g_dut;
    @(posedge clk);
    #1;
    bus_if.int_ready   = ri;
    bus_if.mul_ready   = rm;
    bus_if.div_ready   = rd;
    bus_if.flush_valid = fl;
    rst                = rs;
    #3;
    g_dut = bus_if.issue_div ? 3 : bus_if.issue_mul ? 2 : bus_if.issue_int ? 1 : 0;
    check_eq("grant_onehot",
             32'($countones({bus_if.issue_int, bus_if.issue_mul, bus_if.issue_div}) > 1), 0);
    if (rs) begin
      check_eq("rst_issue_int", bus_if.issue_int, 0);
      check_eq("rst_issue_mul", bus_if.issue_mul, 0);
      check_eq("rst_issue_div", bus_if.issue_div, 0);
      check_eq("rst_cdb_valid", bus_if.cdb_owner_valid, 0);
      check_eq("rst_cdb_owner", bus_if.cdb_owner, 0);
      check_eq("rst_div_busy", bus_if.div_busy, 0);
      check_eq("rst_int_starved", bus_if.int_starved, 0);
      model_clear();
    end else begin
      starved = (m_wait >= 3);
      busy    = (m_cyc < m_div_free);
      cur     = m_slot[m_cyc % 64];
      fi = ri && (m_slot[(m_cyc + 1) % 64] == OWN_NONE);
      fm = rm && (m_slot[(m_cyc + 4) % 64] == OWN_NONE) && !starved;
      fd = rd && (m_slot[(m_cyc + 8) % 64] == OWN_NONE) && !busy && !starved;
      gi = 1'b0; gm = 1'b0; gd = 1'b0;
      if (!fl) begin
        if (starved)  gi = fi;
        else if (fd)  gd = 1'b1;
        else if (fm)  gm = 1'b1;
        else if (fi)  gi = 1'b1;
      end
      check_eq("issue_int", bus_if.issue_int, gi);
      check_eq("issue_mul", bus_if.issue_mul, gm);
      check_eq("issue_div", bus_if.issue_div, gd);
      check_eq("div_busy", bus_if.div_busy, busy);
      check_eq("int_starved", bus_if.int_starved, starved);
      check_eq("cdb_owner", bus_if.cdb_owner, cur);

      // Scoreboard: every op due on the CDB this cycle must show up there.
      matched = 1'b0;
      for (int k = sb_q.size() - 1; k >= 0; k--) begin
        if (sb_q[k].cyc == m_cyc) begin
          check_eq("sb_cdb_valid", bus_if.cdb_owner_valid, !fl);
          check_eq("sb_cdb_owner", bus_if.cdb_owner, sb_q[k].own);
          sb_q.delete(k);
          matched = 1'b1;
        end
      end
      if (!matched) check_eq("sb_cdb_idle", bus_if.cdb_owner_valid, 0);

      if (gi) sb_q.push_back('{m_cyc + 1, OWN_INT});
      if (gm) sb_q.push_back('{m_cyc + 4, OWN_MUL});
      if (gd) sb_q.push_back('{m_cyc + 8, OWN_DIV});

      if (fl) begin
        model_clear();
      end else begin
        m_slot[m_cyc % 64] = OWN_NONE;
        if (gi) m_slot[(m_cyc + 1) % 64] = OWN_INT;
        if (gm) m_slot[(m_cyc + 4) % 64] = OWN_MUL;
        if (gd) begin
          m_slot[(m_cyc + 8) % 64] = OWN_DIV;
          m_div_free = m_cyc + 8;
        end
        if (!ri || gi)      m_wait = 0;
        else if (m_wait < 15) m_wait = m_wait + 1;
      end
    end
    if (eg >= 0) check_eq("dir_grant", g_dut, eg);
    if (eo >= 0) check_eq("dir_cdb_owner", bus_if.cdb_owner, eo);
    if (verbose && g_dut != 0)
      $display("txn cyc=%0d issue=%0d cdb_owner=%0d", m_cyc, g_dut, bus_if.cdb_owner);
    m_cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, -1, -1);
  endtask

  initial begin
    bus_if.int_ready   = 1'b0;
    bus_if.mul_ready   = 1'b0;
    bus_if.div_ready   = 1'b0;
    bus_if.flush_valid = 1'b0;
    model_clear();

    // 1: reset with all readies high, then a reset pulse mid-stream
    step(1, 1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 3, 0);
    step(1, 1, 1, 0, 0, 2, -1);
    step(1, 1, 1, 0, 0, -1, -1);
    step(1, 1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 3, 0);
    idle(12);

    // 2: int+mul, int held; int blocked where mul owns the slot
    step(1, 1, 0, 0, 0, 2, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(4);

    // 3: div+mul held; mul blocked on the div slot, div regrant after 8
    step(0, 1, 1, 0, 0, 3, 0);
    repeat (3) step(0, 1, 1, 0, 0, 2, -1);
    step(0, 1, 1, 0, 0, 0, -1);
    repeat (3) step(0, 1, 1, 0, 0, 2, -1);
    step(0, 1, 1, 0, 0, 3, 3);
    idle(12);

    // 4: integer starvation
    repeat (3) step(1, 1, 0, 0, 0, 2, -1);
    repeat (3) step(1, 1, 0, 0, 0, 0, -1);
    step(1, 1, 0, 0, 0, 1, -1);
    step(1, 1, 0, 0, 0, 2, 1);
    idle(8);

    // 5: flush cancels in-flight div and mul
    step(0, 0, 1, 0, 0, 3, -1);
    step(0, 1, 0, 0, 0, 2, -1);
    step(0, 0, 1, 1, 0, 0, -1);
    step(0, 0, 1, 0, 0, 3, 0);
    idle(10);

    // 6: random readies with occasional flush and reset
    verbose = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 1999) == 0), -1, -1);
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
